// File: rtl/rf_value_probe.sv
// Multi-channel value probe: get, force, release and snapshot of NUM_CH observed values
// through a single-outstanding valid/ready request/response port.
module rf_value_probe #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_value,
    output logic [NUM_CH*DATA_W-1:0] obs_value,
    output logic [NUM_CH-1:0]        force_en,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [$clog2(NUM_CH):0]  req_idx,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic [ERR_CNT_W-1:0]     err_cnt
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int OP_W  = 3;
    localparam logic [IDX_W:0] CH_LIMIT = (IDX_W+1)'(NUM_CH);

    localparam logic [OP_W-1:0] OP_GET_LIVE    = 3'd0;
    localparam logic [OP_W-1:0] OP_GET_SNAP    = 3'd1;
    localparam logic [OP_W-1:0] OP_FORCE       = 3'd2;
    localparam logic [OP_W-1:0] OP_RELEASE     = 3'd3;
    localparam logic [OP_W-1:0] OP_CAPTURE     = 3'd4;
    localparam logic [OP_W-1:0] OP_RELEASE_ALL = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state;
    logic [OP_W-1:0]   op_p0;
    logic [IDX_W:0]    idx_p0;
    logic [DATA_W-1:0] data_p0;
    logic [DATA_W-1:0] force_val [NUM_CH];
    logic [DATA_W-1:0] snap      [NUM_CH];
    logic [DATA_W-1:0] obs_arr   [NUM_CH];
    logic [IDX_W-1:0]  idx_sel;
    logic              req_err;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Forced channels override the raw value with no added latency.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_obs
        assign obs_arr[i] = force_en[i] ? force_val[i] : ch_value[i*DATA_W +: DATA_W];
        assign obs_value[i*DATA_W +: DATA_W] = obs_arr[i];
    end

    assign req_ready = (state == S_IDLE);
    assign idx_sel   = idx_p0[IDX_W-1:0];
    assign req_err   = (op_p0 > OP_RELEASE_ALL) ||
                       ((op_p0 <= OP_RELEASE) && (idx_p0 >= CH_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_p0     <= '0;
            idx_p0    <= '0;
            data_p0   <= '0;
            force_en  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_cnt   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                force_val[i] <= '0;
                snap[i]      <= '0;
            end
        end else begin
            case (state)
                // Request accept: latch the command
                S_IDLE: begin
                    if (req_valid) begin
                        op_p0   <= req_op;
                        idx_p0  <= req_idx;
                        data_p0 <= req_data;
                        state   <= S_EXEC;
                    end
                end
                // Execute: all effects land on this edge
                S_EXEC: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= req_err;
                    rsp_data  <= '0;
                    if (req_err) begin
                        err_cnt <= sat_inc(err_cnt);
                    end else begin
                        case (op_p0)
                            OP_GET_LIVE: rsp_data <= obs_arr[idx_sel];
                            OP_GET_SNAP: rsp_data <= snap[idx_sel];
                            OP_FORCE: begin
                                force_val[idx_sel] <= data_p0;
                                force_en[idx_sel]  <= 1'b1;
                            end
                            OP_RELEASE: force_en[idx_sel] <= 1'b0;
                            OP_CAPTURE: begin
                                for (int i = 0; i < NUM_CH; i++) snap[i] <= obs_arr[i];
                            end
                            OP_RELEASE_ALL: force_en <= '0;
                            default: ;
                        endcase
                    end
                end
                // Response hold until accepted
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
